opb_status_bank_simulink2ppc: RTL and testbench
===============================================

// Module: opb_status_bank_simulink2ppc
// PURPOSE
//  Multi-channel successor to the single status readback register. C_NUM_REGS 32-bit user status words are captured coherently into shadow registers on one strobe.
//  The PPC reads them over the OPB, along with a control word and a capture counter.
//  Single clock domain: the user logic runs on OPB_Clk. Sits on the OPB alongside the other simulink2ppc slaves.
// PARAMETERS
//  C_BASEADDR    32'h01083100  window base (word aligned)
//  C_HIGHADDR    32'h010831FF  window top; window must hold >= C_NUM_REGS+2 words
//  C_OPB_AWIDTH  32            OPB address width
//  C_OPB_DWIDTH  32            OPB data width
//  C_NUM_REGS    4             status channels, legal range 1..32
//  C_FAMILY      "virtex6"     target family (informational)
// PORTS
//  OPB_Clk       in   1                  sole clock; all logic rising-edge
//  OPB_Rst       in   1                  synchronous, active-high reset
//  OPB_ABus      in   [0:31]             address
//  OPB_BE        in   [0:3]              byte enables
//  OPB_DBus      in   [0:31]             write data
//  OPB_RNW       in   1                  1=read, 0=write
//  OPB_select    in   1                  transfer request
//  OPB_seqAddr   in   1                  ignored
//  Sl_DBus       out  [0:31]             read data; zero when not acking
//  Sl_errAck     out  1                  tied 0
//  Sl_retry      out  1                  tied 0
//  Sl_toutSup    out  1                  tied 0
//  Sl_xferAck    out  1                  transfer acknowledge
//  user_data_in  in   [C_NUM_REGS*32-1:0] channel k = bits [32k+31:32k]
//  user_valid    in   1                  capture strobe, all channels at once
// BEHAVIOUR
//  Word map (offset from C_BASEADDR, in 32-bit words):
//   - 0..C_NUM_REGS-1: shadow[k], read-only.
//   - C_NUM_REGS: CTRL; bit0 = freeze (R/W), bit1 = clear (write-1 pulse, reads 0).
//   - C_NUM_REGS+1: CAPCNT, read-only.
//   - Other in-window words: read 0; writes acked and ignored.
//  Bit order: OPB big-endian. Sl_DBus[0] = bit31 of the word; CTRL bits 1:0 = OPB_DBus[30:31].
//  CTRL writes take effect only when OPB_BE[3]=1.
//  hit = OPB_select & (OPB_ABus >= C_BASEADDR) & (OPB_ABus <= C_HIGHADDR).
//  FSM IDLE -> ACK -> WAIT:
//   - IDLE: on hit, register address/RNW/data -> ACK.
//   - ACK: Sl_xferAck=1 for exactly one cycle; read data driven this cycle only; write applied at end of this cycle -> WAIT.
//   - WAIT: -> IDLE when OPB_select=0. No second ack while select stays high.
//  Latency: ack in cycle N+1 for a hit first seen in cycle N.
//  Read coherency: read data = shadow/CTRL/CAPCNT as registered at the end of cycle N.
//   A capture in cycle N+1 is not visible in that read.
//  Capture, when user_valid=1 and freeze=0:
//   - shadow <= user_data_in (all channels in the same cycle).
//   - CAPCNT <= CAPCNT+1; wraps 32'hFFFFFFFF -> 0.
//  When freeze=1: user_valid is ignored; shadow and CAPCNT hold.
//  Clear write (bit1=1), STATUS_STICKY_EN defined: CAPCNT <= 0 and shadow <= 0.
//   If a capture occurs in the same cycle, its data and a count of 1 win.
//  Clear write, STATUS_STICKY_EN not defined: CAPCNT <= 0 only; shadow unchanged.
//  Reset, including mid-transaction:
//   - FSM -> IDLE; Sl_xferAck=0; Sl_DBus=0.
//   - shadow, CTRL and CAPCNT = 0.
//   - The aborted transfer is never acked.
//  Non-hit select (another slave): no response, state stays IDLE.
// CONFIGURATION
//  STATUS_STICKY_EN defined:
//   - Capture is shadow <= shadow | user_data_in (sticky error/overflow flags).
//   - Bits stay high until a CTRL clear write.
//  STATUS_STICKY_EN undefined:
//   - Capture overwrites shadow.
//   - CTRL clear resets CAPCNT only.
// TESTING
//  - Reset then read words 0..5 (C_NUM_REGS=4) -> each acked in 1 cycle; all read 0.
//  - user_data_in ch0..3 = 11111111/22222222/33333333/44444444, user_valid 1 cycle -> reads return those words; CAPCNT=1.
//  - Write CTRL=1 (freeze), pulse user_valid with AAAAAAAA on all channels -> shadow and CAPCNT unchanged; unfreeze -> next strobe captures.
//  - Hold select high 5 cycles -> exactly one Sl_xferAck pulse; Sl_DBus=0 outside the ack cycle.
//  - Assert OPB_Rst in ACK/WAIT -> no ack, FSM IDLE; next read acked normally with 0 data.
//  - Sticky: capture 00000001 then 00000100 -> read 00000101 (00000100 without macro). Clear -> 0; CAPCNT 32'hFFFFFFFF + strobe -> 0.

Source files
------------

// File: rtl/opb_status_bank_simulink2ppc.sv
// opb_status_bank_simulink2ppc
//
// Purpose: bank of C_NUM_REGS 32-bit user status words, captured coherently
// into shadow registers on a single strobe, readable by the PPC over OPB
// together with a control word (freeze/clear) and a capture counter.
//
// Word map (offset from C_BASEADDR in 32-bit words):
//   0..C_NUM_REGS-1 : shadow[k]            (RO)
//   C_NUM_REGS      : CTRL bit0 freeze (RW), bit1 clear (W1 pulse, reads 0)
//   C_NUM_REGS+1    : CAPCNT               (RO)
//   other in-window : read 0, writes acked and ignored
//
// Ports:
//   OPB_Clk, OPB_Rst          clock, synchronous active-high reset
//   OPB_ABus/BE/DBus/RNW      OPB request (big-endian bit numbering)
//   OPB_select, OPB_seqAddr   transfer request; seqAddr ignored
//   Sl_DBus, Sl_xferAck       read data (0 unless acking a read), ack
//   Sl_errAck/retry/toutSup   tied 0
//   user_data_in, user_valid  channel k = bits [32k+31:32k], capture strobe
//
// Build option: define STATUS_STICKY_EN to make captures OR into the shadow
// registers (sticky flags) and to make a CTRL clear also zero the shadows.

module opb_status_bank_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'h01083100,
    parameter logic [31:0] C_HIGHADDR   = 32'h010831FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 4,
    parameter              C_FAMILY     = "virtex6"
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic                      Sl_xferAck,
    input  logic [C_NUM_REGS*32-1:0]  user_data_in,
    input  logic                      user_valid
);

    // state  | meaning
    // S_IDLE | waiting for a hit; request is registered on entry to S_ACK
    // S_ACK  | one-cycle acknowledge; read data driven, write committed
    // S_WAIT | transfer done, waiting for OPB_select to drop
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        w_hit;
    logic [31:0] w_offset;
    logic [29:0] r_word;
    logic        r_rnw;
    logic [1:0]  r_wbits;    // [1] clear, [0] freeze
    logic        r_be3;

    logic [31:0] r_shadow [C_NUM_REGS];
    logic        r_freeze;
    logic [31:0] r_capcnt;
    logic [31:0] w_rdata;

    logic        w_ctrl_wr;
    logic        w_clear;
    logic        w_capture;
    logic        w_unused_ok;

    assign w_hit    = OPB_select
                    && (32'(OPB_ABus) >= C_BASEADDR)
                    && (32'(OPB_ABus) <= C_HIGHADDR);
    assign w_offset = 32'(OPB_ABus) - C_BASEADDR;

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_state <= S_IDLE;
            r_word  <= '0;
            r_rnw   <= 1'b1;
            r_wbits <= '0;
            r_be3   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_hit) begin
                r_word  <= w_offset[31:2];
                r_rnw   <= OPB_RNW;
                r_wbits <= {OPB_DBus[C_OPB_DWIDTH-2], OPB_DBus[C_OPB_DWIDTH-1]};
                r_be3   <= OPB_BE[C_OPB_DWIDTH/8-1];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_hit) w_state_nxt = S_ACK;
            S_ACK:   w_state_nxt = S_WAIT;
            S_WAIT:  if (!OPB_select) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Writes commit at the end of the ack cycle; freeze is sampled before
    // the write lands, so a capture in that same cycle uses the old freeze.
    assign w_ctrl_wr = (r_state == S_ACK) && !r_rnw && r_be3
                    && (r_word == 30'(C_NUM_REGS));
    assign w_clear   = w_ctrl_wr && r_wbits[1];
    assign w_capture = user_valid && !r_freeze;

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            for (int k = 0; k < C_NUM_REGS; k++) r_shadow[k] <= '0;
            r_freeze <= 1'b0;
            r_capcnt <= '0;
        end else begin
            if (w_ctrl_wr) r_freeze <= r_wbits[0];

            // A capture coinciding with a clear wins: fresh data, count 1.
            for (int k = 0; k < C_NUM_REGS; k++) begin
                if (w_capture) begin
`ifdef STATUS_STICKY_EN
                    r_shadow[k] <= (w_clear ? 32'd0 : r_shadow[k])
                                 | user_data_in[32*k +: 32];
`else
                    r_shadow[k] <= user_data_in[32*k +: 32];
`endif
                end
`ifdef STATUS_STICKY_EN
                else if (w_clear) begin
                    r_shadow[k] <= '0;
                end
`endif
            end

            if (w_capture)    r_capcnt <= w_clear ? 32'd1 : r_capcnt + 32'd1;
            else if (w_clear) r_capcnt <= '0;
        end
    end

    // Registers read combinationally during ACK, so the data is the state
    // at the end of the hit cycle; a capture during ACK lands afterwards.
    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < C_NUM_REGS; k++) begin
            if (r_word == 30'(k)) w_rdata = r_shadow[k];
        end
        if (r_word == 30'(C_NUM_REGS))          w_rdata = {31'd0, r_freeze};
        else if (r_word == 30'(C_NUM_REGS + 1)) w_rdata = r_capcnt;
    end

    // Gated by reset so a transfer aborted in its ack cycle is never acked.
    assign Sl_xferAck = (r_state == S_ACK) && !OPB_Rst;
    assign Sl_DBus    = (Sl_xferAck && r_rnw) ? C_OPB_DWIDTH'(w_rdata) : '0;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    assign w_unused_ok = ^{OPB_seqAddr, OPB_BE, OPB_DBus, w_offset[1:0],
                           (C_FAMILY == "virtex6")};

endmodule

// File: tb/tb_opb_status_bank_simulink2ppc.sv
module tb_opb_status_bank_simulink2ppc;

    localparam logic [31:0] BASE = 32'h01083100;
    localparam logic [31:0] HIGH = 32'h010831FF;
    localparam int          NR   = 4;
`ifdef STATUS_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic             clk;
    logic             OPB_Rst;
    logic [0:31]      OPB_ABus;
    logic [0:3]       OPB_BE;
    logic [0:31]      OPB_DBus;
    logic             OPB_RNW;
    logic             OPB_select;
    logic             OPB_seqAddr;
    logic [0:31]      Sl_DBus;
    logic             Sl_errAck;
    logic             Sl_retry;
    logic             Sl_toutSup;
    logic             Sl_xferAck;
    logic [NR*32-1:0] user_data_in;
    logic             user_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    // reference model state
    logic [31:0] sh_m [NR];
    bit          frz_m;
    logic [31:0] cnt_m;

    opb_status_bank_simulink2ppc dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (OPB_Rst),
        .OPB_ABus     (OPB_ABus),
        .OPB_BE       (OPB_BE),
        .OPB_DBus     (OPB_DBus),
        .OPB_RNW      (OPB_RNW),
        .OPB_select   (OPB_select),
        .OPB_seqAddr  (OPB_seqAddr),
        .Sl_DBus      (Sl_DBus),
        .Sl_errAck    (Sl_errAck),
        .Sl_retry     (Sl_retry),
        .Sl_toutSup   (Sl_toutSup),
        .Sl_xferAck   (Sl_xferAck),
        .user_data_in (user_data_in),
        .user_valid   (user_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    // monitor: every ack pops one expectation; outside acks the bus must be 0
    initial begin
        forever begin
            @(negedge clk);
            if (Sl_xferAck === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: ack=1 with no transfer pending at %0t", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.is_read) check("read_data", 32'(Sl_DBus), e.data);
                end
            end else begin
                check("dbus_idle_zero", 32'(Sl_DBus), 32'd0);
            end
        end
    end

    function automatic logic [31:0] model_read(input int w);
        if (w < NR)      return sh_m[w];
        if (w == NR)     return {31'd0, frz_m};
        if (w == NR + 1) return cnt_m;
        return 32'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NR; k++) sh_m[k] = '0;
        frz_m = 1'b0;
        cnt_m = '0;
    endtask

    // one clock edge of the model: optional capture, optional CTRL write
    task automatic model_edge(input bit strobe, input logic [NR*32-1:0] d,
                              input bit ctrl_wr, input logic [31:0] wd);
        bit cap;
        bit clr;
        cap = strobe && !frz_m;
        clr = ctrl_wr && wd[1];
        for (int k = 0; k < NR; k++) begin
            if (cap) begin
                if (STICKY && !clr) sh_m[k] = sh_m[k] | d[32*k +: 32];
                else                sh_m[k] = d[32*k +: 32];
            end else if (clr && STICKY) begin
                sh_m[k] = '0;
            end
        end
        if (cap)      cnt_m = clr ? 32'd1 : cnt_m + 32'd1;
        else if (clr) cnt_m = '0;
        if (ctrl_wr) frz_m = wd[0];
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic strobe(input logic [NR*32-1:0] d);
        user_data_in = d;
        user_valid   = 1'b1;
        @(posedge clk);
        model_edge(1'b1, d, 1'b0, 32'd0);
        #1;
        user_valid = 1'b0;
    endtask

    task automatic xfer(input bit rnw, input int word, input logic [31:0] wd,
                        input logic [0:3] be, input bit cap_in_ack,
                        input logic [NR*32-1:0] cd);
        exp_t e;
        bit   ctrl_wr;
        e.is_read = rnw;
        e.data    = rnw ? model_read(word) : 32'd0;
        exp_q.push_back(e);
        OPB_ABus   = BASE + 32'(word * 4);
        OPB_RNW    = rnw;
        OPB_DBus   = wd;
        OPB_BE     = be;
        OPB_select = 1'b1;
        @(posedge clk);
        #1;
        if (cap_in_ack) begin
            user_data_in = cd;
            user_valid   = 1'b1;
        end
        @(negedge clk);
        check("ack_latency", {31'd0, Sl_xferAck}, 32'd1);
        @(posedge clk);
        ctrl_wr = !rnw && (word == NR) && be[3];
        model_edge(cap_in_ack, cd, ctrl_wr, wd);
        #1;
        user_valid = 1'b0;
        OPB_select = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int word);
        xfer(1'b1, word, 32'd0, 4'b1111, 1'b0, '0);
    endtask

    task automatic wr_ctrl(input logic [31:0] wd);
        xfer(1'b0, NR, wd, 4'b1111, 1'b0, '0);
    endtask

    task automatic no_ack_select(input logic [31:0] addr, input string name);
        int acks;
        acks = 0;
        OPB_ABus   = addr;
        OPB_RNW    = 1'b1;
        OPB_select = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (Sl_xferAck === 1'b1) acks++;
        end
        @(posedge clk);
        #1;
        OPB_select = 1'b0;
        check(name, 32'(acks), 32'd0);
    endtask

    function automatic logic [NR*32-1:0] rand_data();
        logic [NR*32-1:0] d;
        for (int k = 0; k < NR; k++) d[32*k +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        int acks;
        OPB_Rst      = 1'b1;
        OPB_ABus     = '0;
        OPB_BE       = '0;
        OPB_DBus     = '0;
        OPB_RNW      = 1'b1;
        OPB_select   = 1'b0;
        OPB_seqAddr  = 1'b0;
        user_data_in = '0;
        user_valid   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ack", {31'd0, Sl_xferAck}, 32'd0);
        check("tied_outputs", {29'd0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'd0);
        @(posedge clk);
        #1;
        OPB_Rst = 1'b0;

        // reset values over the whole map plus one spare in-window word
        for (int w = 0; w < NR + 3; w++) rd(w);

        // basic capture
        strobe({32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        for (int w = 0; w < NR + 2; w++) rd(w);
        check("capcnt_one", cnt_m, 32'd1);

        // freeze blocks capture, unfreeze restores it
        wr_ctrl(32'd1);
        strobe({4{32'hAAAAAAAA}});
        for (int w = 0; w < NR + 2; w++) rd(w);
        wr_ctrl(32'd0);
        strobe({4{32'hAAAAAAAA}});
        for (int w = 0; w < NR + 2; w++) rd(w);

        // BE[3]=0 means the CTRL write has no effect
        xfer(1'b0, NR, 32'd1, 4'b1110, 1'b0, '0);
        rd(NR);

        // select held high: exactly one ack
        begin
            exp_t e;
            e.is_read = 1'b1;
            e.data    = model_read(1);
            exp_q.push_back(e);
            acks = 0;
            OPB_ABus   = BASE + 32'd4;
            OPB_RNW    = 1'b1;
            OPB_select = 1'b1;
            repeat (6) begin
                @(negedge clk);
                if (Sl_xferAck === 1'b1) acks++;
            end
            check("single_ack", 32'(acks), 32'd1);
            @(posedge clk);
            #1;
            OPB_select = 1'b0;
            @(posedge clk);
            #1;
        end

        // non-hit selects just outside the window
        no_ack_select(HIGH + 32'd1, "nohit_above");
        no_ack_select(BASE - 32'd4, "nohit_below");
        @(posedge clk);
        #1;

        // reset during the ack cycle
        OPB_ABus   = BASE;
        OPB_RNW    = 1'b1;
        OPB_select = 1'b1;
        @(posedge clk);
        #1;
        OPB_Rst    = 1'b1;
        OPB_select = 1'b0;
        @(negedge clk);
        check("rst_in_ack_noack", {31'd0, Sl_xferAck}, 32'd0);
        @(posedge clk);
        #1;
        OPB_Rst = 1'b0;
        model_reset();
        rd(0);
        rd(NR + 1);

        // reset during wait with select still high
        strobe(rand_data());
        begin
            exp_t e;
            e.is_read = 1'b1;
            e.data    = model_read(2);
            exp_q.push_back(e);
            OPB_ABus   = BASE + 32'd8;
            OPB_select = 1'b1;
            @(posedge clk);
            @(posedge clk);
            #1;
            OPB_Rst    = 1'b1;
            OPB_select = 1'b0;
            @(posedge clk);
            #1;
            OPB_Rst = 1'b0;
            model_reset();
            acks = 0;
            repeat (2) begin
                @(negedge clk);
                if (Sl_xferAck === 1'b1) acks++;
            end
            check("rst_in_wait_noack", 32'(acks), 32'd0);
            @(posedge clk);
            #1;
        end
        for (int w = 0; w < NR + 2; w++) rd(w);

        // sticky versus overwrite
        strobe({4{32'h00000001}});
        strobe({4{32'h00000100}});
        rd(0);
        check("sticky_model", sh_m[0], STICKY ? 32'h00000101 : 32'h00000100);
        wr_ctrl(32'd2);
        rd(0);
        rd(NR + 1);
        rd(NR);

        // capture and clear in the same cycle
        strobe({4{32'h0F0F0F0F}});
        xfer(1'b0, NR, 32'd2, 4'b0001, 1'b1, {4{32'h00C0FFEE}});
        for (int w = 0; w < NR + 2; w++) rd(w);

        // counter wrap
        force dut.r_capcnt = 32'hFFFFFFFF;
        #1;
        release dut.r_capcnt;
        cnt_m = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        rd(NR + 1);
        strobe(rand_data());
        rd(NR + 1);
        check("capcnt_wrap_model", cnt_m, 32'd0);

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            int op;
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2:    strobe(rand_data());
                3, 4, 5, 6: rd($urandom_range(0, NR + 3));
                7: xfer(1'b0, NR,
                        {30'd0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0)},
                        4'($urandom), 1'b0, '0);
                8: xfer(1'b0, $urandom_range(0, NR - 1), $urandom, 4'b1111, 1'b0, '0);
                default: xfer(1'b0, NR, {30'd0, 1'($urandom), 1'b0}, 4'b1111,
                              1'b1, rand_data());
            endcase
        end

        repeat (4) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
